// File: rtl/vx_ahb_sram_subordinate.sv
// vx_ahb_sram_subordinate
// AHB-Lite subordinate in front of a word-addressed on-chip SRAM.
// Pipelined address/data phases, WAIT_STATES extra data-phase cycles per
// transfer, byte-strobed writes.
// Optional feature macro: VX_AHB_SUB_ERR_EN
//   defined   -> out-of-range / oversize / misaligned transfers get a
//                two-cycle ERROR response and never touch the SRAM.
//   undefined -> no error decode; addresses wrap modulo DEPTH_WORDS,
//                HSIZE > 2 acts as a word, HRESP is tied to OKAY.
// dbg_state exposes the FSM state for checkers.

module vx_ahb_sram_subordinate #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [31:0]           HWDATA,
    input  logic [3:0]            HWSTRB,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [2:0]            dbg_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // Counter preload: WAIT lasts WAIT_STATES cycles (counter WAIT_STATES-1 .. 0).
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
`ifdef VX_AHB_SUB_ERR_EN
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;
`endif

    // Handshake: an address phase is "valid" when HSEL & HTRANS[1] (NONSEQ or
    // SEQ) and is taken only on an edge where HREADY is high; HREADYOUT is this
    // block's "ready", high whenever the current data phase ends this cycle
    // (or there is none), so the next address phase overlaps it with no bubble.

    logic [2:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic             write_q;
    logic [2:0]       size_q;
    logic [1:0]       lane_q;

    logic [31:0]      mem [0:DEPTH_WORDS-1];

    logic                  bus_ready;
    logic                  addr_accept;
    logic [ADDR_WIDTH-1:0] addr_off;
    logic [IDX_W-1:0]      acc_idx;
    logic [2:0]            accept_next;
    logic [3:0]            lane_mask;
    logic [3:0]            byte_en;
    logic                  wr_commit;

    // Only IDLE / DATA / ERR2 can start a new data phase.
    assign bus_ready   = HREADYOUT;
    assign addr_accept = HSEL & HREADY & HTRANS[1] & bus_ready;

    // BASE_ADDR is aligned to the SRAM size, so the low offset bits are the index.
    assign addr_off = HADDR - BASE_ADDR;
    assign acc_idx  = addr_off[IDX_W+1:2];

`ifdef VX_AHB_SUB_ERR_EN
    logic out_of_range;
    logic size_bad;
    logic misaligned;
    logic acc_err;

    // Error decode for the address phase currently on the bus.
    always_comb begin
        out_of_range = |addr_off[ADDR_WIDTH-1:IDX_W+2];
        size_bad     = (HSIZE > 3'd2);
        misaligned   = ((HSIZE == 3'd1) && HADDR[0]) ||
                       ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
        acc_err      = out_of_range | size_bad | misaligned;
    end
`endif

    // Where an accepted address phase sends the FSM.
    always_comb begin
        accept_next = (WAIT_STATES == 0) ? ST_DATA : ST_WAIT;
`ifdef VX_AHB_SUB_ERR_EN
        if (acc_err) begin
            accept_next = ST_ERR1;
        end
`endif
    end

    // Next-state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
`ifdef VX_AHB_SUB_ERR_EN
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
`endif
            default: begin
                // IDLE, DATA and ERR2 all behave alike: take a new phase or go idle.
                if (addr_accept) begin
                    state_d = accept_next;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // FSM and counter registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the address-phase attributes the data phase needs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            lane_q  <= 2'b00;
        end else if (addr_accept) begin
            idx_q   <= acc_idx;
            write_q <= HWRITE;
            size_q  <= HSIZE;
            lane_q  <= HADDR[1:0];
        end
    end

    // Byte lanes touched by the transfer size; anything above half is a word.
    always_comb begin
        case (size_q)
            3'd0:    lane_mask = 4'b0001 << lane_q;
            3'd1:    lane_mask = lane_q[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    assign byte_en   = HWSTRB & lane_mask;
    assign wr_commit = (state_q == ST_DATA) & write_q;

    // SRAM write port: commits on the edge that ends the DATA cycle; no reset.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Response outputs decoded straight from the state.
    always_comb begin
        HREADYOUT = (state_q != ST_WAIT);
        HRESP     = 1'b0;
`ifdef VX_AHB_SUB_ERR_EN
        if (state_q == ST_ERR1) begin
            HREADYOUT = 1'b0;
        end
        HRESP = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`endif
    end

    // Read data is live through the whole non-error data phase, zero elsewhere.
    always_comb begin
        if ((state_q == ST_WAIT) || (state_q == ST_DATA)) begin
            HRDATA = mem[idx_q];
        end else begin
            HRDATA = 32'd0;
        end
    end

    assign dbg_state = state_q;

    // Inputs that carry no information for this block.
    logic unused_sigs;
    assign unused_sigs = &{1'b0, HBURST, HTRANS[0], addr_off[1:0]
`ifndef VX_AHB_SUB_ERR_EN
                           , addr_off[ADDR_WIDTH-1:IDX_W+2]
`endif
                          };

    // A WAIT cycle never sees a counter beyond the configured wait count.
    wait_cnt_bounded: assert property (@(posedge clk) disable iff (!reset)
        (state_q == ST_WAIT) |-> (cnt_q < 3'(WAIT_STATES)));

`ifdef VX_AHB_SUB_ERR_EN
    // The ERROR response is always exactly two cycles.
    err1_then_err2: assert property (@(posedge clk) disable iff (!reset)
        (state_q == ST_ERR1) |=> (state_q == ST_ERR2));
`endif

endmodule

// File: tb/tb_vx_ahb_sram_subordinate.sv
// tb_vx_ahb_sram_subordinate
// Three instances (0, 3 and 5 wait states) with private bus signals, HREADY
// looped back from each HREADYOUT. A pipelined driver applies vector tables;
// read expectations go into exp_q at address time and are popped when the
// data phase completes.

module tb_vx_ahb_sram_subordinate;

`ifdef VX_AHB_SUB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          err;
        logic [31:0] rdata;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- per-instance bus signals ----------------
    logic        hsel     [3];
    logic [31:0] haddr    [3];
    logic [1:0]  htrans   [3];
    logic        hwrite   [3];
    logic [2:0]  hsize    [3];
    logic [2:0]  hburst   [3];
    logic [31:0] hwdata   [3];
    logic [3:0]  hwstrb   [3];
    logic        hreadyout[3];
    logic        hresp    [3];
    logic [31:0] hrdata   [3];
    logic [2:0]  dbg      [3];

    vx_ahb_sram_subordinate #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst_n), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWDATA(hwdata[0]),
        .HWSTRB(hwstrb[0]), .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]),
        .HRESP(hresp[0]), .HRDATA(hrdata[0]), .dbg_state(dbg[0]));

    vx_ahb_sram_subordinate #(.WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(rst_n), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWDATA(hwdata[1]),
        .HWSTRB(hwstrb[1]), .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]),
        .HRESP(hresp[1]), .HRDATA(hrdata[1]), .dbg_state(dbg[1]));

    vx_ahb_sram_subordinate #(.WAIT_STATES(5)) dut2 (
        .clk(clk), .reset(rst_n), .HSEL(hsel[2]), .HADDR(haddr[2]), .HTRANS(htrans[2]),
        .HWRITE(hwrite[2]), .HSIZE(hsize[2]), .HBURST(hburst[2]), .HWDATA(hwdata[2]),
        .HWSTRB(hwstrb[2]), .HREADY(hreadyout[2]), .HREADYOUT(hreadyout[2]),
        .HRESP(hresp[2]), .HRDATA(hrdata[2]), .dbg_state(dbg[2]));

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    vec_t        seq[$];
    int          tests  = 0;
    int          failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input bit err, input logic [31:0] rdata);
        vec_t v;
        v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
        v.wstrb = wstrb; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle(input int d);
        hsel[d]   = 1'b1;
        htrans[d] = 2'b00;
        hwrite[d] = 1'b0;
        haddr[d]  = 32'd0;
        hsize[d]  = 3'd2;
        hburst[d] = 3'd0;
    endtask

    task automatic drive_addr(input int d, input vec_t v);
        hsel[d]   = 1'b1;
        htrans[d] = 2'b10;
        hwrite[d] = v.wr;
        haddr[d]  = v.addr;
        hsize[d]  = v.size;
        hburst[d] = 3'd0;
    endtask

    // Runs seq[] back-to-back on instance d; span = cycles from first accept
    // edge to the edge that completes the last data phase.
    task automatic run_seq(input int d, input int ws, output int span);
        vec_t dp;
        vec_t pend;
        bit   have_dp   = 1'b0;
        bit   have_pend = 1'b0;
        bit   done      = 1'b0;
        int   ai        = 0;
        int   waits     = 0;
        int   acc_cyc   = 0;
        int   done_cyc  = 0;
        int   budget    = 0;
        logic [31:0] exp;
        dp   = mk(0, 0, 0, 0, 0, 0, 0);
        pend = dp;
        while (!done) begin
            @(negedge clk);
            if (have_pend) begin
                dp        = pend;
                have_dp   = 1'b1;
                have_pend = 1'b0;
                waits     = 0;
                hwdata[d] = pend.wdata;
                hwstrb[d] = pend.wstrb;
            end
            if (have_dp) begin
                if (hreadyout[d] == 1'b0) begin
                    waits++;
                    check($sformatf("wait_hresp[%0d]@%h", d, dp.addr), 32'(hresp[d]), 32'(dp.err));
                end else begin
                    check($sformatf("wait_count[%0d]@%h", d, dp.addr), waits, dp.err ? 1 : ws);
                    check($sformatf("hresp[%0d]@%h", d, dp.addr), 32'(hresp[d]), 32'(dp.err));
                    if (!dp.wr || dp.err) begin
                        exp = exp_q.pop_front();
                        check($sformatf("hrdata[%0d]@%h", d, dp.addr), hrdata[d], exp);
                    end
                    have_dp  = 1'b0;
                    done_cyc = cyc + 1;
                end
            end
            if (hreadyout[d] == 1'b1) begin
                if (ai < seq.size()) begin
                    drive_addr(d, seq[ai]);
                    pend      = seq[ai];
                    have_pend = 1'b1;
                    if (ai == 0) acc_cyc = cyc + 1;
                    if (!seq[ai].wr || seq[ai].err) exp_q.push_back(seq[ai].err ? 32'd0 : seq[ai].rdata);
                    ai++;
                end else begin
                    drive_idle(d);
                end
            end
            if (ai >= seq.size() && !have_dp && !have_pend) done = 1'b1;
            budget++;
            if (!done && budget > 400) begin
                tests++;
                failed++;
                $display("FAIL timeout[%0d]: %0d vectors issued, data phase still open", d, ai);
                drive_idle(d);
                exp_q.delete();
                done = 1'b1;
            end
        end
        span = done_cyc - acc_cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_hreadyout[%0d]", tag, d), 32'(hreadyout[d]), 32'd1);
            check($sformatf("%s_hresp[%0d]", tag, d), 32'(hresp[d]), 32'd0);
            check($sformatf("%s_hrdata[%0d]", tag, d), hrdata[d], 32'd0);
            check($sformatf("%s_state[%0d]", tag, d), 32'(dbg[d]), 32'd0);
        end
    endtask

    // ---------------- test sequence ----------------
    vec_t        tbl[19];
    logic [31:0] model[8];
    int          span;

    initial begin
        // Directed vector table; expectations are hand-derived per build.
        tbl[0]  = mk(1, 32'h00, 3'd2, 32'h01020304, 4'hF, 0, 0);
        tbl[1]  = mk(1, 32'h10, 3'd2, 32'hDEADBEEF, 4'hF, 0, 0);
        tbl[2]  = mk(0, 32'h10, 3'd2, 0, 0, 0, 32'hDEADBEEF);
        tbl[3]  = mk(1, 32'h20, 3'd2, 32'h11223344, 4'hF, 0, 0);
        tbl[4]  = mk(1, 32'h22, 3'd0, 32'h00AA0000, 4'h4, 0, 0);
        tbl[5]  = mk(0, 32'h20, 3'd2, 0, 0, 0, 32'h11AA3344);
        tbl[6]  = mk(1, 32'h22, 3'd1, 32'h55660000, 4'hF, 0, 0);
        tbl[7]  = mk(0, 32'h20, 3'd2, 0, 0, 0, 32'h55663344);
        tbl[8]  = mk(1, 32'h24, 3'd2, 32'hCAFEF00D, 4'hF, 0, 0);
        tbl[9]  = mk(1, 32'h24, 3'd0, 32'hFFFFFF77, 4'hE, 0, 0);
        tbl[10] = mk(0, 32'h24, 3'd2, 0, 0, 0, 32'hCAFEF00D);
        tbl[11] = mk(0, 32'h1000, 3'd2, 0, 0, ERR_EN, ERR_EN ? 32'h0 : 32'h01020304);
        tbl[12] = mk(1, 32'h02, 3'd2, 32'hFFFFFFFF, 4'hF, ERR_EN, 0);
        tbl[13] = mk(0, 32'h00, 3'd2, 0, 0, 0, ERR_EN ? 32'h01020304 : 32'hFFFFFFFF);
        tbl[14] = mk(0, 32'h10, 3'd3, 0, 0, ERR_EN, ERR_EN ? 32'h0 : 32'hDEADBEEF);
        tbl[15] = mk(1, 32'h11, 3'd1, 32'h00009999, 4'h3, ERR_EN, 0);
        tbl[16] = mk(0, 32'h10, 3'd2, 0, 0, 0, ERR_EN ? 32'hDEADBEEF : 32'hDEAD9999);
        tbl[17] = mk(1, 32'h27, 3'd0, 32'h5A000000, 4'h8, 0, 0);
        tbl[18] = mk(0, 32'h24, 3'd2, 0, 0, 0, 32'h5AFEF00D);

        for (int d = 0; d < 3; d++) begin
            drive_idle(d);
            hwdata[d] = 32'd0;
            hwstrb[d] = 4'h0;
        end

        // Reset held for 3 cycles with the bus idle.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        rst_n = 1'b1;

        // BUSY and unselected NONSEQ must not open a data phase.
        for (int d = 0; d < 3; d++) htrans[d] = 2'b01;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("busy");
        for (int d = 0; d < 3; d++) begin
            hsel[d]   = 1'b0;
            htrans[d] = 2'b10;
        end
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("unsel");
        for (int d = 0; d < 3; d++) drive_idle(d);

        // Vector table on the zero-wait and three-wait instances.
        seq.delete();
        foreach (tbl[i]) seq.push_back(tbl[i]);
        run_seq(0, 0, span);
        run_seq(1, 3, span);

        // Two back-to-back reads: 2 cycles with no waits, 8 with three waits.
        seq.delete();
        seq.push_back(mk(0, 32'h10, 3'd2, 0, 0, 0, ERR_EN ? 32'hDEADBEEF : 32'hDEAD9999));
        seq.push_back(mk(0, 32'h20, 3'd2, 0, 0, 0, 32'h55663344));
        run_seq(0, 0, span);
        check("b2b_span_ws0", span, 2);
        run_seq(1, 3, span);
        check("b2b_span_ws3", span, 8);

        // Randomised strobed writes/reads against a byte-merge model.
        seq.delete();
        for (int i = 0; i < 8; i++) begin
            model[i] = $urandom;
            seq.push_back(mk(1, 32'h100 + 32'(4 * i), 3'd2, model[i], 4'hF, 0, 0));
        end
        for (int k = 0; k < 24; k++) begin
            int          w;
            logic [31:0] dv;
            logic [3:0]  sv;
            w = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                dv = $urandom;
                sv = 4'($urandom_range(0, 15));
                for (int b = 0; b < 4; b++) if (sv[b]) model[w][8*b +: 8] = dv[8*b +: 8];
                seq.push_back(mk(1, 32'h100 + 32'(4 * w), 3'd2, dv, sv, 0, 0));
            end else begin
                seq.push_back(mk(0, 32'h100 + 32'(4 * w), 3'd2, 0, 0, 0, model[w]));
            end
        end
        run_seq(0, 0, span);
        run_seq(1, 3, span);

        // Reset two cycles into a five-wait write: write is dropped.
        seq.delete();
        seq.push_back(mk(1, 32'h40, 3'd2, 32'h12345678, 4'hF, 0, 0));
        seq.push_back(mk(0, 32'h40, 3'd2, 0, 0, 0, 32'h12345678));
        run_seq(2, 5, span);
        @(negedge clk);
        drive_addr(2, mk(1, 32'h40, 3'd2, 0, 0, 0, 0));
        @(negedge clk);
        drive_idle(2);
        hwdata[2] = 32'hFFFFFFFF;
        hwstrb[2] = 4'hF;
        check("rstmid_pre_hreadyout", 32'(hreadyout[2]), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rstmid_pre_hrdata", hrdata[2], 32'h12345678);
        rst_n = 1'b0;
        #1;
        check("rstmid_hreadyout", 32'(hreadyout[2]), 32'd1);
        check("rstmid_hresp", 32'(hresp[2]), 32'd0);
        check("rstmid_hrdata", hrdata[2], 32'd0);
        check("rstmid_state", 32'(dbg[2]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seq.delete();
        seq.push_back(mk(0, 32'h40, 3'd2, 0, 0, 0, 32'h12345678));
        run_seq(2, 5, span);
        check("rstmid_read_span", span, 6);

        repeat (2) @(negedge clk);
        check("final_expq_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vx_ahb_sram_subordinate.md
# vx_ahb_sram_subordinate

AHB-Lite subordinate that fronts a word-addressed on-chip SRAM and answers the transfers issued by the Vortex AHB manager adapter (HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA/HWSTRB in; HREADY/HRESP/HRDATA out). It is the memory-side endpoint for the `Vortex_ahb` wrapper in simulation and FPGA bring-up. It provides:
- a pipelined address/data phase;
- a programmable number of wait states;
- a byte-strobed write path;
- an optional two-cycle ERROR response for illegal transfers.

## Interface
- `ADDR_WIDTH`, 32: HADDR width.
- `DEPTH_WORDS`, 1024: SRAM depth in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: first byte address decoded; aligned to DEPTH_WORDS*4.
- `WAIT_STATES`, 0: extra data-phase cycles per transfer, 0..7.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `HSEL` in 1: subordinate select.
- `HADDR` in ADDR_WIDTH: byte address.
- `HTRANS` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `HWRITE` in 1: 1 = write.
- `HSIZE` in 3: 0 byte, 1 half, 2 word.
- `HBURST` in 3: accepted but ignored; every beat is decoded independently.
- `HWDATA` in 32: write data, valid in the data phase.
- `HWSTRB` in 4: write byte strobes, valid in the data phase.
- `HREADY` in 1: bus ready, used to qualify address-phase sampling.
- `HREADYOUT` out 1: data phase complete.
- `HRESP` out 1: 0 OKAY, 1 ERROR.
- `HRDATA` out 32: read data.

## Operation
- **Address-phase accept.** An address phase is accepted on a rising edge where `HSEL & HREADY & HTRANS[1]`.
  - On accept, register: word index, HWRITE, HSIZE, HADDR[1:0], and an error flag.
  - IDLE, BUSY, or unselected cycles: no data phase is created; the response is OKAY with zero waits.
- **Error flag.** Set when any of the following holds:
  - address outside [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4);
  - HSIZE > 2;
  - misaligned (half with HADDR[0] = 1, or word with HADDR[1:0] ≠ 0).
- **FSM states:**
  - IDLE: no pending data phase.
  - WAIT: waiting, counter running.
  - DATA: data phase completes this cycle.
  - ERR1: first ERROR cycle.
  - ERR2: second ERROR cycle.
- **FSM transitions, on accept from IDLE/DATA/ERR2:**
  - error flag set → ERR1;
  - else WAIT_STATES = 0 → DATA;
  - else → WAIT, with counter = WAIT_STATES − 1.
- **WAIT:** counter decrements; → DATA when it reaches 0.
- **DATA / ERR2 without a new accept:** → IDLE.
- **ERR1:** → ERR2 unconditionally.
- **Outputs by state:**
  - HREADYOUT = 0 in WAIT and ERR1, 1 otherwise.
  - HRESP = 1 in ERR1/ERR2, 0 otherwise.
- **Write commit.** Occurs on the DATA-state edge.
  - Per-byte enable = HWSTRB[i] AND size-lane mask.
  - Size-lane mask: byte → lane HADDR[1:0]; half → lanes {HADDR[1],0} and {HADDR[1],1}; word → all four lanes.
  - A masked-out strobe leaves that byte unchanged.
- **Read path.** HRDATA = SRAM[word index], combinational from the registered index, in WAIT/DATA; 0 in all other states.
- **ERROR transfers** never modify the SRAM.
- **SRAM contents** are not reset.

## Timing
- **Reset values:** state IDLE, counter 0, HREADYOUT 1, HRESP 0, HRDATA 0.
- **Reset assertion mid-transfer:** asynchronously returns the block to IDLE; any write in flight is dropped.
- **Data-phase latency:** WAIT_STATES + 1 cycles after the accept edge.
- **Back-to-back transfers:** pipelined, no bubble. The next address phase is accepted on the same edge that completes DATA.
- **Write followed by read of the same word:** the read returns the new data, because the write commits before the read data phase.
- **ERROR response:** two cycles, (HREADYOUT 0, HRESP 1) then (1, 1).
  - An address phase presented during ERR1 is not sampled, since HREADY is 0.
  - An address phase presented during ERR2 is accepted normally.
- **Addressing:** SEQ beats are treated exactly like NONSEQ. Word index = (HADDR − BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.

## Configuration
- `VX_AHB_SUB_ERR_EN`
  - **Defined:** error decoding and the ERR1/ERR2 states as above.
  - **Undefined:**
    - the error flag is tied to 0 and ERR states are removed;
    - out-of-range addresses wrap modulo DEPTH_WORDS;
    - HSIZE > 2 is treated as word;
    - misaligned transfers use the lane mask computed from HADDR[1:0] unchanged;
    - HRESP is constant 0.

## Test plan
- **Reset then idle:** reset low for 3 cycles, HTRANS = IDLE → HREADYOUT 1, HRESP 0, HRDATA 0 throughout.
- **Zero-wait pipelining:** WAIT_STATES = 0; NONSEQ write 0xDEADBEEF to 0x10, HWSTRB 0xF, then an immediately following read of 0x10 → read data phase returns 0xDEADBEEF with no wait cycle.
- **Byte strobes:** word 0x20 = 0x11223344; byte write 0xAA to 0x22 (HSIZE 0, HWSTRB 0x4) → a subsequent read returns 0x11AA3344.
- **Wait states:** WAIT_STATES = 3; read 0x0 → HREADYOUT low for exactly 3 cycles, then high with valid data; 2 back-to-back reads complete in 8 cycles.
- **Error path (macro defined):** word read at BASE_ADDR + DEPTH_WORDS*4 → HREADYOUT/HRESP = (0, 1) then (1, 1); a write to 0x2 with HSIZE 2 errors and word 0 is unchanged.
- **Reset mid-wait:** WAIT_STATES = 5; assert reset 2 cycles into a write's data phase → outputs return to reset values immediately and the target word is unchanged.
